// File: rtl/sprite_plotter.sv
// Rasterises a fixed-size press/garbage sprite into vga_adapter pixel writes, one pixel per clock.
// Optional macro SPRITE_OUTLINE_EN: non-erase commands plot only the sprite border.
module sprite_plotter #(
  parameter int          SPRITE_W     = 8,
  parameter int          SPRITE_H     = 8,
  parameter int          X_BASE       = 20,
  parameter int          LANE_PITCH   = 32,
  parameter int          PRESS_Y      = 20,
  parameter int          GARB_Y       = 80,
  parameter logic [2:0]  PRESS_COLOUR = 3'b111,
  parameter logic [2:0]  GARB_COLOUR  = 3'b010,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       item,
  input  logic       erase,
  input  logic [2:0] position,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam logic [7:0] COL_LAST   = 8'(SPRITE_W - 1);
  localparam logic [6:0] ROW_LAST   = 7'(SPRITE_H - 1);
  localparam logic [6:0] PRESS_Y7   = 7'(PRESS_Y);
  localparam logic [6:0] GARB_Y7    = 7'(GARB_Y);

  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

  state_t     state;
  logic [7:0] col;
  logic [6:0] row;
  logic       item_r;
  logic       erase_r;
  logic [7:0] lane_x_r;
  logic       pix_en;

  // Press positions fold back across the four lanes: 0,1,2,3,2,1.
  function automatic logic [7:0] lane_x_of(input logic it, input logic [2:0] pos);
    logic [2:0] lane;
    lane = (it && pos > 3'd3) ? 3'd6 - pos : pos;
    return 8'(X_BASE + LANE_PITCH * int'(lane));
  endfunction

  function automatic logic cmd_valid(input logic it, input logic [2:0] pos);
    return it ? (pos <= 3'd5) : (pos <= 3'd3);
  endfunction

`ifdef SPRITE_OUTLINE_EN
  assign pix_en = erase_r || (row == 7'd0) || (row == ROW_LAST) ||
                  (col == 8'd0) || (col == COL_LAST);
`else
  assign pix_en = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      plot     <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      col      <= '0;
      row      <= '0;
      item_r   <= 1'b0;
      erase_r  <= 1'b0;
      lane_x_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          plot <= 1'b0;
          // done still high here means this is the completion cycle; its start is ignored.
          if (start && !done) begin
            item_r   <= item;
            erase_r  <= erase;
            lane_x_r <= lane_x_of(item, position);
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= cmd_valid(item, position) ? PLOT : DONE;
          end
        end
        PLOT: begin
          plot <= pix_en;
          if (pix_en) begin
            x      <= lane_x_r + col;
            y      <= (item_r ? PRESS_Y7 : GARB_Y7) + row;
            colour <= erase_r ? BG_COLOUR : (item_r ? PRESS_COLOUR : GARB_COLOUR);
          end
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) state <= DONE;
            else                 row   <= row + 7'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
        DONE: begin
          plot  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected pixels are queued when a command is issued.
module tb_sprite_plotter;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       item;
  logic       erase;
  logic [2:0] position;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  always #10 clock = ~clock;

  sprite_plotter dut (
    .clock(clock), .reset(reset), .start(start), .item(item), .erase(erase),
    .position(position), .busy(busy), .done(done), .x(x), .y(y),
    .colour(colour), .plot(plot)
  );

  // Every plotted pixel must match the next expected pixel in scan order.
  always @(negedge clock) begin
    logic [17:0] e;
    if (plot === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pixel_unexpected got x=%0d y=%0d c=%0d, required no plot", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          n_fail++;
          $display("FAIL pixel got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   x, y, colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic push_expected(input logic it, input logic er, input logic [2:0] pos);
    int lane, lx, by;
    logic [2:0] c;
    logic border;
    if (it ? (pos > 3'd5) : (pos > 3'd3)) return;
    if (it) lane = (pos <= 3'd3) ? int'(pos) : 6 - int'(pos);
    else    lane = int'(pos);
    lx = 20 + 32 * lane;
    by = it ? 20 : 80;
    c  = er ? 3'b000 : (it ? 3'b111 : 3'b010);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        border = (r == 0) || (r == 7) || (k == 0) || (k == 7);
`ifdef SPRITE_OUTLINE_EN
        if (er || border) exp_q.push_back({8'(lx + k), 7'(by + r), c});
`else
        if (er || border || 1'b1) exp_q.push_back({8'(lx + k), 7'(by + r), c});
`endif
      end
    end
  endtask

  // Called at a negedge; start is sampled by the next rising edge (edge k).
  task automatic issue(input logic it, input logic er, input logic [2:0] pos);
    item = it; erase = er; position = pos; start = 1'b1;
    push_expected(it, er, pos);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Observes ncyc cycles after edge k; start is held high for edges hold_from..hold_to.
  task automatic watch(input int ncyc, input int hold_from, input int hold_to,
                       output int nplots, output int first_p, output int last_p,
                       output int done_cyc, output int ndone, output int busy_lo);
    nplots = 0; first_p = 0; last_p = 0; done_cyc = 0; ndone = 0; busy_lo = 0;
    for (int n = 1; n <= ncyc; n++) begin
      start = (n >= hold_from) && (n <= hold_to);
      @(negedge clock);
      if (plot === 1'b1) begin
        nplots++;
        if (first_p == 0) first_p = n;
        last_p = n;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (busy !== 1'b1 && busy_lo == 0) busy_lo = n;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; item = 1'b0; erase = 1'b0; position = 3'd0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, plot} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl got busy/done/plot=%b, required 000", {busy, done, plot});
    end
    n_checks++;
    if ({x, y, colour} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_data got x=%0d y=%0d c=%0d, required 0", x, y, colour);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_full(input string name, input logic it, input logic er,
                           input logic [2:0] pos, input int want_plots);
    int np, fp, lp, dc, nd, bl;
    issue(it, er, pos);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start got %b, required 1", name, busy);
    end
    watch(70, 0, -1, np, fp, lp, dc, nd, bl);
    n_checks++;
    if (np !== want_plots) begin
      n_fail++;
      $display("FAIL %s plot_count got %0d, required %0d", name, np, want_plots);
    end
    n_checks++;
    if (fp !== 1 || lp !== 64) begin
      n_fail++;
      $display("FAIL %s plot_window got %0d..%0d, required 1..64", name, fp, lp);
    end
    n_checks++;
    if (dc !== 65 || nd !== 1) begin
      n_fail++;
      $display("FAIL %s done got cycle %0d count %0d, required cycle 65 count 1", name, dc, nd);
    end
    n_checks++;
    if (bl !== 66) begin
      n_fail++;
      $display("FAIL %s busy_low got cycle %0d, required 66", name, bl);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s leftover_pixels got %0d, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_invalid(input logic it, input logic [2:0] pos);
    int np, fp, lp, dc, nd, bl;
    issue(it, 1'b0, pos);
    watch(4, 0, -1, np, fp, lp, dc, nd, bl);
    n_checks++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL invalid_plots item=%b pos=%0d got %0d, required 0", it, pos, np);
    end
    n_checks++;
    if (dc !== 1 || nd !== 1 || bl !== 2) begin
      n_fail++;
      $display("FAIL invalid_timing item=%b pos=%0d got done=%0d n=%0d busy_low=%0d, required 1 1 2",
               it, pos, dc, nd, bl);
    end
  endtask

  task automatic test_back_to_back();
    int np, fp, lp, dc, nd, bl;
    issue(1'b1, 1'b0, 3'd1);
    // start stays high from mid-plot through the done cycle and must be ignored throughout
    watch(66, 6, 66, np, fp, lp, dc, nd, bl);
    n_checks++;
    if (np !== 64 || dc !== 65 || nd !== 1 || bl !== 66) begin
      n_fail++;
      $display("FAIL ignore_start got plots=%0d done=%0d n=%0d busy_low=%0d, required 64 65 1 66",
               np, dc, nd, bl);
    end
    issue(1'b0, 1'b0, 3'd2);
    watch(70, 0, -1, np, fp, lp, dc, nd, bl);
    n_checks++;
    if (fp !== 1 || dc !== 65 || bl !== 66) begin
      n_fail++;
      $display("FAIL first_idle_start got first=%0d done=%0d busy_low=%0d, required 1 65 66",
               fp, dc, bl);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL back_to_back leftover got %0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    int np, fp, lp, dc, nd, bl;
    issue(1'b1, 1'b0, 3'd2);
    watch(30, 0, -1, np, fp, lp, dc, nd, bl);
    n_checks++;
    if (np !== 30 || nd !== 0) begin
      n_fail++;
      $display("FAIL abort_prefix got plots=%0d done=%0d, required 30 0", np, nd);
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_reset got plot/busy/done=%b, required 000", {plot, busy, done});
    end
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    n_checks++;
    if ({plot, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle got plot/busy/done=%b, required 000", {plot, busy, done});
    end
    test_full("after_abort", 1'b1, 1'b0, 3'd2, 64);
  endtask

  initial begin
    test_reset();
    test_full("press_p0", 1'b1, 1'b0, 3'd0, 64);
    test_full("press_p4", 1'b1, 1'b0, 3'd4, 64);
    test_full("garb_erase_l3", 1'b0, 1'b1, 3'd3, 64);
    test_invalid(1'b0, 3'd5);
    test_invalid(1'b1, 3'd6);
    test_back_to_back();
    test_reset_abort();
`ifdef SPRITE_OUTLINE_EN
    test_full("garb_outline_l1", 1'b0, 1'b0, 3'd1, 28);
    test_full("press_erase_p5", 1'b1, 1'b1, 3'd5, 64);
`else
    test_full("garb_fill_l1", 1'b0, 1'b0, 3'd1, 64);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
